// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - shared types and defaults for the 9-bit CPU program-flow front end
package instr_pack;

  // Run-control states shared by the sequencer and anything that observes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } seq_state_t;

  localparam int DEF_PC_W      = 10;
  localparam int DEF_RAS_DEPTH = 4;
  localparam int DEF_CNT_W     = 16;

  // True in the states where start is allowed to launch a new run
  function automatic logic is_launchable(seq_state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// rtl/pc_sequencer_ras_stack.sv - return-address stack, pointer based with registered storage
module ras_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  // count holds 0..DEPTH, so it needs one more code than an entry index
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Top of stack is the entry just below the fill pointer; reads zero when empty
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == int'(count) - 1) begin
        dout = mem[i];
      end
    end
  end

  // Fill pointer and storage; clear wipes contents so nothing leaks into the next run
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(count)) begin
          mem[i] <= din;
        end
      end
      count <= count + ONE;
    end else if (pop && !empty) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - run handshake, program counter, call/return stack and run-cycle counter
module pc_sequencer
  import instr_pack::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter logic [PC_W-1:0] PROG_BASE = '0,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int              CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [PC_W-1:0]  branch_tgt,
  output logic [PC_W-1:0]  p,
  output logic             fetch_en,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

  seq_state_t      state;
  logic            active;
  logic            stk_clr;
  logic            stk_push;
  logic            stk_pop;
  logic            stk_empty;
  logic            stk_full;
  logic [PC_W-1:0] stk_dout;
  logic [PC_W-1:0] p_seq;

  // Sequential successor; the natural wrap of PC_W bits is the intended behaviour
  assign p_seq = p + PC_ONE;

  // Only the state and stall reach an output combinationally
  assign fetch_en = (state == RUN) && !stall;

  // Stack strobes follow the same priority as the PC mux: halt beats ret beats call
  always_comb begin
    active   = (state == RUN) && !stall;
    stk_clr  = is_launchable(state) && start;
    stk_pop  = active && !halt && ret_en;
    stk_push = active && !halt && !ret_en && call_en;
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (p_seq),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // Run-control FSM with registered PC, done/err flags and saturating cycle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      p      <= PROG_BASE;
      done   <= 1'b0;
      err    <= 1'b0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state  <= RUN;
            p      <= PROG_BASE;
            done   <= 1'b0;
            err    <= 1'b0;
            cycles <= '0;
          end
        end
        RUN: begin
          // Stalled cycles and the terminating cycle are both part of the run
          if (cycles != CNT_MAX) begin
            cycles <= cycles + CNT_ONE;
          end
          if (!stall) begin
            if (halt) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (ret_en) begin
              if (stk_empty) begin
                state <= ERR;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                p <= stk_dout;
              end
            end else if (call_en) begin
              if (stk_full) begin
                state <= ERR;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                p <= branch_tgt;
              end
            end else if (branch_en) begin
              p <= branch_tgt;
            end else begin
              p <= p_seq;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
  import instr_pack::*;

  localparam int PCW     = 10;
  localparam int DEPTH   = 4;
  localparam int CNTW    = 16;
  localparam int PC_MOD  = 1 << PCW;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, stall, halt, branch_en, call_en, ret_en;
  logic [PCW-1:0]  branch_tgt;
  logic [PCW-1:0]  p;
  logic            fetch_en, done, err;
  logic [CNTW-1:0] cycles;

  logic            s_rst_n, s_start, s_halt;
  logic [3:0]      s_p;
  logic            s_fetch_en, s_done, s_err;
  logic [3:0]      s_cycles;

  pc_sequencer #(.PC_W(PCW), .PROG_BASE('0), .RAS_DEPTH(DEPTH), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en), .branch_tgt(branch_tgt),
    .p(p), .fetch_en(fetch_en), .done(done), .err(err), .cycles(cycles)
  );

  pc_sequencer #(.PC_W(4), .PROG_BASE(4'd0), .RAS_DEPTH(DEPTH), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .stall(1'b0), .halt(s_halt),
    .branch_en(1'b0), .call_en(1'b0), .ret_en(1'b0), .branch_tgt(4'd0),
    .p(s_p), .fetch_en(s_fetch_en), .done(s_done), .err(s_err), .cycles(s_cycles)
  );

  int tests = 0;
  int fails = 0;

  bit m_run;
  bit m_done;
  bit m_err;
  int m_p;
  int m_cycles;
  int m_stack[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_err = 0; m_p = 0; m_cycles = 0;
      m_stack.delete();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_err = 0; m_p = 0; m_cycles = 0;
        m_stack.delete();
      end
    end else begin
      if (m_cycles < CNT_MAX) m_cycles++;
      if (!stall) begin
        if (halt) begin
          m_run = 0; m_done = 1;
        end else if (ret_en) begin
          if (m_stack.size() == 0) begin
            m_run = 0; m_done = 1; m_err = 1;
          end else begin
            m_p = m_stack.pop_back();
          end
        end else if (call_en) begin
          if (m_stack.size() == DEPTH) begin
            m_run = 0; m_done = 1; m_err = 1;
          end else begin
            m_stack.push_back((m_p + 1) % PC_MOD);
            m_p = int'(branch_tgt);
          end
        end else if (branch_en) begin
          m_p = int'(branch_tgt);
        end else begin
          m_p = (m_p + 1) % PC_MOD;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("p", 32'(p), 32'(m_p));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    check("cycles", 32'(cycles), 32'(m_cycles));
    check("fetch_en", 32'(fetch_en), 32'(m_run && !stall));
  endtask

  task automatic clear_ctl();
    start = 0; stall = 0; halt = 0; branch_en = 0; call_en = 0; ret_en = 0; branch_tgt = '0;
  endtask

  initial begin
    rst_n = 0; clear_ctl();
    s_rst_n = 0; s_start = 0; s_halt = 0;

    // Reset and launch
    tick(); tick();
    check("rst_p", 32'(p), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1; start = 1; tick();
    check("launch_p", 32'(p), 32'd0);
    check("launch_fetch", 32'(fetch_en), 32'd1);
    start = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("step_p", 32'(p), 32'(k));
    end

    // Nested call and return
    tick(); tick();
    check("pre_call_p", 32'(p), 32'd5);
    call_en = 1; branch_tgt = 10'h100; tick(); call_en = 0;
    check("call1_p", 32'(p), 32'h100);
    tick(); tick();
    check("in_sub1_p", 32'(p), 32'h102);
    call_en = 1; branch_tgt = 10'h200; tick(); call_en = 0;
    check("call2_p", 32'(p), 32'h200);
    tick();
    ret_en = 1; tick();
    check("ret1_p", 32'(p), 32'h103);
    tick(); ret_en = 0;
    check("ret2_p", 32'(p), 32'd6);

    // Overflow on the fifth nested call
    for (int k = 1; k <= 4; k++) begin
      call_en = 1; branch_tgt = PCW'(k * 16); tick();
    end
    branch_tgt = 10'h050; tick(); call_en = 0;
    check("ovf_p", 32'(p), 32'h040);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_err", 32'(err), 32'd1);
    tick();
    check("ovf_hold_p", 32'(p), 32'h040);
    start = 1; tick(); start = 0;
    check("relaunch_p", 32'(p), 32'd0);
    check("relaunch_err", 32'(err), 32'd0);

    // Underflow, then halt priority over call and branch
    ret_en = 1; tick(); ret_en = 0;
    check("udf_err", 32'(err), 32'd1);
    check("udf_p", 32'(p), 32'd0);
    start = 1; tick(); start = 0;
    for (int k = 0; k < 7; k++) tick();
    check("pre_halt_p", 32'(p), 32'd7);
    halt = 1; call_en = 1; branch_en = 1; branch_tgt = 10'h3ff; tick(); clear_ctl();
    check("halt_p", 32'(p), 32'd7);
    check("halt_done", 32'(done), 32'd1);
    check("halt_err", 32'(err), 32'd0);

    // Stall holds the PC but the counter keeps running
    start = 1; tick(); start = 0;
    for (int k = 0; k < 4; k++) tick();
    stall = 1; tick(); tick(); tick();
    check("stall_p", 32'(p), 32'd4);
    check("stall_fetch", 32'(fetch_en), 32'd0);
    check("stall_cycles", 32'(cycles), 32'd7);
    halt = 1; tick(); halt = 0;
    check("stall_halt_ignored", 32'(done), 32'd0);
    stall = 0; tick();
    check("post_stall_p", 32'(p), 32'd5);
    halt = 1; tick(); halt = 0;

    // Narrow instance: PC wrap, counter saturation, mid-run reset
    tick(); tick();
    check("s_rst_p", 32'(s_p), 32'd0);
    check("s_rst_cycles", 32'(s_cycles), 32'd0);
    s_rst_n = 1; s_start = 1; tick(); s_start = 0;
    check("s_launch_fetch", 32'(s_fetch_en), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k >= 14) check("s_wrap_p", 32'(s_p), 32'(k % 16));
      check("s_cycles", 32'(s_cycles), 32'(k < 15 ? k : 15));
    end
    s_rst_n = 0; tick();
    check("s_midrst_p", 32'(s_p), 32'd0);
    check("s_midrst_cycles", 32'(s_cycles), 32'd0);
    check("s_midrst_done", 32'(s_done), 32'd0);
    check("s_midrst_fetch", 32'(s_fetch_en), 32'd0);
    s_rst_n = 1; tick();
    check("s_idle_p", 32'(s_p), 32'd0);
    s_start = 1; tick(); s_start = 0;
    for (int k = 0; k < 20; k++) tick();
    check("s_sat_cycles", 32'(s_cycles), 32'd15);
    check("s_sat_p", 32'(s_p), 32'd4);
    s_halt = 1; tick(); s_halt = 0;
    check("s_halt_done", 32'(s_done), 32'd1);
    check("s_halt_err", 32'(s_err), 32'd0);
    check("s_halt_cycles", 32'(s_cycles), 32'd15);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 59) != 0);
      start      = $urandom_range(0, 1);
      stall      = ($urandom_range(0, 4) == 0);
      halt       = ($urandom_range(0, 24) == 0);
      ret_en     = ($urandom_range(0, 5) == 0);
      call_en    = ($urandom_range(0, 4) == 0);
      branch_en  = ($urandom_range(0, 6) == 0);
      branch_tgt = PCW'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
